// File: rtl/axis_int_divider_pkg.sv
// Shared constants and types for the iterative integer divider.
// Both the signed (DIV) and unsigned (DIVU) instances import this package.
package div_pkg;

    localparam int WIDTH            = 32;
    localparam int DIV_LAT_SIGNED   = 36;
    localparam int DIV_LAT_UNSIGNED = 34;

    localparam logic [WIDTH-1:0] DIV_BY_ZERO_QUOT = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } div_state_t;

endpackage

// File: rtl/axis_int_divider_if.sv
// Operand and result stream bundle for axis_int_divider.
// slave = divider side, master = the EX-stage side that feeds it.
interface axis_int_divider_if #(
    parameter int WIDTH = 32
);

    logic               s_axis_divisor_tvalid;
    logic [WIDTH-1:0]   s_axis_divisor_tdata;
    logic               s_axis_divisor_tready;
    logic               s_axis_dividend_tvalid;
    logic [WIDTH-1:0]   s_axis_dividend_tdata;
    logic               s_axis_dividend_tready;
    logic               m_axis_dout_tvalid;
    logic               m_axis_dout_tuser;
    logic [2*WIDTH-1:0] m_axis_dout_tdata;

    modport slave (
        input  s_axis_divisor_tvalid,
        input  s_axis_divisor_tdata,
        output s_axis_divisor_tready,
        input  s_axis_dividend_tvalid,
        input  s_axis_dividend_tdata,
        output s_axis_dividend_tready,
        output m_axis_dout_tvalid,
        output m_axis_dout_tuser,
        output m_axis_dout_tdata
    );

    modport master (
        output s_axis_divisor_tvalid,
        output s_axis_divisor_tdata,
        input  s_axis_divisor_tready,
        output s_axis_dividend_tvalid,
        output s_axis_dividend_tdata,
        input  s_axis_dividend_tready,
        input  m_axis_dout_tvalid,
        input  m_axis_dout_tuser,
        input  m_axis_dout_tdata
    );

endinterface

// File: rtl/axis_int_divider_core.sv
// Restoring shift-subtract divider on unsigned magnitudes, one quotient bit
// per cycle; results stay valid after done until the next start.
module div_core_unsigned #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;
    logic [CW-1:0]    bits_left;
    logic             busy;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // rem_q < divisor is invariant, so the MSB of trial is a clean borrow flag
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dsr_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            bits_left <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                rem_q     <= '0;
                quo_q     <= dividend;
                dsr_q     <= divisor;
                bits_left <= CW'(WIDTH);
                busy      <= 1'b1;
            end else if (busy) begin
                rem_q     <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                quo_q     <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                bits_left <= bits_left - CW'(1);
                if (bits_left == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/axis_int_divider.sv
// Fixed-latency integer divider with valid handshakes: wraps the magnitude
// core with sign handling, divide-by-zero flagging and a latency pad timer.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | treadys high; accepts when both operand valids are high
//   ST_BUSY | core iterating; pad timer counts down to the result edge
module axis_int_divider #(
    parameter int SIGNED  = 1,
    parameter int WIDTH   = div_pkg::WIDTH,
    parameter int LATENCY = (SIGNED != 0) ? div_pkg::DIV_LAT_SIGNED
                                          : div_pkg::DIV_LAT_UNSIGNED
) (
    input  logic               aclk,
    input  logic               aresetn,
    axis_int_divider_if.slave  axis
);

    import div_pkg::*;

    localparam int CW = $clog2(LATENCY + 1);

    div_state_t       state;
    logic [CW-1:0]    pad_cnt;
    logic             accept;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] core_quo;
    logic [WIDTH-1:0] core_rem;
    logic             core_done;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             q_neg;
    logic             r_neg;
    logic             zero_div;
    logic [WIDTH-1:0] dvd_raw;

    assign accept = (state == ST_IDLE) && axis.s_axis_divisor_tvalid
                    && axis.s_axis_dividend_tvalid;

    assign a_neg = (SIGNED != 0) && axis.s_axis_dividend_tdata[WIDTH-1];
    assign b_neg = (SIGNED != 0) && axis.s_axis_divisor_tdata[WIDTH-1];
    assign a_mag = a_neg ? -axis.s_axis_dividend_tdata : axis.s_axis_dividend_tdata;
    assign b_mag = b_neg ? -axis.s_axis_divisor_tdata  : axis.s_axis_divisor_tdata;

    div_core_unsigned #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (aclk),
        .rst_n     (aresetn),
        .start     (accept),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (core_quo),
        .remainder (core_rem),
        .done      (core_done)
    );

    // The most-negative / -1 case wraps back onto itself, which is the wanted result
    assign q_fix = q_neg ? -q_mag : q_mag;
    assign r_fix = r_neg ? -r_mag : r_mag;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state                   <= ST_IDLE;
            pad_cnt                 <= '0;
            q_mag                   <= '0;
            r_mag                   <= '0;
            q_neg                   <= 1'b0;
            r_neg                   <= 1'b0;
            zero_div                <= 1'b0;
            dvd_raw                 <= '0;
            axis.m_axis_dout_tvalid <= 1'b0;
            axis.m_axis_dout_tuser  <= 1'b0;
            axis.m_axis_dout_tdata  <= '0;
        end else begin
            axis.m_axis_dout_tvalid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_BUSY;
                        pad_cnt  <= CW'(LATENCY - 1);
                        q_neg    <= a_neg ^ b_neg;
                        r_neg    <= a_neg;
                        zero_div <= (axis.s_axis_divisor_tdata == '0);
                        dvd_raw  <= axis.s_axis_dividend_tdata;
                    end
                end
                ST_BUSY: begin
                    if (core_done) begin
                        q_mag <= core_quo;
                        r_mag <= core_rem;
                    end
                    if (pad_cnt == '0) begin
                        state                   <= ST_IDLE;
                        axis.m_axis_dout_tvalid <= 1'b1;
                        axis.m_axis_dout_tuser  <= zero_div;
                        axis.m_axis_dout_tdata  <= zero_div
                            ? {WIDTH'(DIV_BY_ZERO_QUOT), dvd_raw}
                            : {q_fix, r_fix};
                    end else begin
                        pad_cnt <= pad_cnt - CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign axis.s_axis_divisor_tready  = (state == ST_IDLE);
    assign axis.s_axis_dividend_tready = (state == ST_IDLE);

endmodule

// File: tb/tb_axis_int_divider.sv
// Bench for the signed and unsigned divider instances against an arithmetic
// reference model; directed corner cases followed by random operands.
module tb_axis_int_divider;

    localparam int LAT_S = 36;
    localparam int LAT_U = 34;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    axis_int_divider_if #(.WIDTH(32)) si ();
    axis_int_divider_if #(.WIDTH(32)) ui ();

    axis_int_divider #(.SIGNED(1), .WIDTH(32), .LATENCY(LAT_S)) u_sdiv (
        .aclk    (clk),
        .aresetn (rst_n),
        .axis    (si)
    );

    axis_int_divider #(.SIGNED(0), .WIDTH(32), .LATENCY(LAT_U)) u_udiv (
        .aclk    (clk),
        .aresetn (rst_n),
        .axis    (ui)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {tuser, quotient, remainder} from plain integer arithmetic
    function automatic logic [64:0] ref_div(input bit sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'h0) return {1'b1, 32'hFFFF_FFFF, a};
        if (!sgn) return {1'b0, a / b, a % b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h8000_0000, 32'h0};
        sa = a;
        sb = b;
        return {1'b0, 32'(sa / sb), 32'(sa % sb)};
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic vld(input bit sel);
        return sel ? si.m_axis_dout_tvalid : ui.m_axis_dout_tvalid;
    endfunction

    function automatic logic rdy(input bit sel);
        return sel ? (si.s_axis_divisor_tready & si.s_axis_dividend_tready)
                   : (ui.s_axis_divisor_tready & ui.s_axis_dividend_tready);
    endfunction

    function automatic logic [64:0] res(input bit sel);
        return sel ? {si.m_axis_dout_tuser, si.m_axis_dout_tdata}
                   : {ui.m_axis_dout_tuser, ui.m_axis_dout_tdata};
    endfunction

    task automatic drive(input bit sel, input logic vdsr, input logic vdvd,
                         input logic [31:0] a, input logic [31:0] b);
        if (sel) begin
            si.s_axis_divisor_tvalid  = vdsr;
            si.s_axis_dividend_tvalid = vdvd;
            si.s_axis_dividend_tdata  = a;
            si.s_axis_divisor_tdata   = b;
        end else begin
            ui.s_axis_divisor_tvalid  = vdsr;
            ui.s_axis_dividend_tvalid = vdvd;
            ui.s_axis_dividend_tdata  = a;
            ui.s_axis_divisor_tdata   = b;
        end
    endtask

    task automatic do_op(input bit sel, input logic [31:0] a, input logic [31:0] b);
        logic [64:0] want;
        int          lat;
        int          k;
        bit          seen;
        want = ref_div(sel, a, b);
        lat  = sel ? LAT_S : LAT_U;
        @(negedge clk);
        chk("tready_idle", 96'(rdy(sel)), 96'(1));
        drive(sel, 1'b1, 1'b1, a, b);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, $urandom, $urandom);
        chk("tready_busy", 96'(rdy(sel)), 96'(0));
        k    = 0;
        seen = 1'b0;
        while (!seen && k < lat + 5) begin
            @(posedge clk);
            #1;
            k++;
            if (vld(sel)) seen = 1'b1;
        end
        chk(sel ? "latency_s" : "latency_u", 96'(k), 96'(lat));
        chk(sel ? "result_s" : "result_u", 96'(res(sel)), 96'(want));
        @(posedge clk);
        #1;
        chk("strobe_one_cycle", 96'(vld(sel)), 96'(0));
        chk("result_hold", 96'(res(sel)), 96'(want));
    endtask

    initial begin
        int          cyc;
        int          pulses;
        int          first_p;
        int          second_p;
        bit          ok;
        bit          sel;
        logic [31:0] a;
        logic [31:0] b;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_s", 96'({rdy(1'b1), vld(1'b1), res(1'b1)}), 96'({1'b1, 1'b0, 65'h0}));
        chk("reset_u", 96'({rdy(1'b0), vld(1'b0), res(1'b0)}), 96'({1'b1, 1'b0, 65'h0}));
        @(negedge clk);
        rst_n = 1'b1;

        do_op(1'b1, 32'd100, 32'd7);
        chk("lit_100_7", 96'(res(1'b1)), 96'({1'b0, 32'h0000_000E, 32'h0000_0002}));
        do_op(1'b1, 32'hFFFF_FFF9, 32'h2);
        chk("lit_m7_2", 96'(res(1'b1)), 96'({1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF}));
        do_op(1'b0, 32'hFFFF_FFF9, 32'h2);
        chk("lit_m7_2_u", 96'(res(1'b0)), 96'({1'b0, 32'h7FFF_FFFC, 32'h0000_0001}));
        do_op(1'b1, 32'h1234_5678, 32'h0);
        do_op(1'b0, 32'h1234_5678, 32'h0);
        chk("lit_dbz_u", 96'(res(1'b0)), 96'({1'b1, 32'hFFFF_FFFF, 32'h1234_5678}));
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(1'b0, 32'hFFFF_FFFF, 32'h1);
        do_op(1'b1, 32'h8000_0000, 32'h0000_0001);
        do_op(1'b1, 32'h0000_0005, 32'hFFFF_FFF9);

        for (int i = 0; i < 24; i++) begin
            sel = 1'($urandom_range(0, 1));
            a   = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 200));
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 15));
                2: b = -32'($urandom_range(1, 15));
                3: b = $urandom >> $urandom_range(1, 30);
                default: b = 32'h0;
            endcase
            do_op(sel, a, b);
        end

        // both valids held: a fresh accept follows every strobe
        a = 32'hFFFF_FF9C;
        b = 32'd9;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, a, b);
        cyc      = 0;
        pulses   = 0;
        first_p  = -1;
        second_p = -1;
        repeat (80) begin
            @(posedge clk);
            #1;
            cyc++;
            if (vld(1'b1)) begin
                pulses++;
                if (first_p < 0) first_p = cyc;
                else if (second_p < 0) second_p = cyc;
                chk("b2b_result", 96'(res(1'b1)), 96'(ref_div(1'b1, a, b)));
            end
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("b2b_pulses", 96'(pulses), 96'(2));
        chk("b2b_spacing", 96'(second_p - first_p), 96'(LAT_S + 1));
        cyc = 0;
        while (!vld(1'b1) && cyc < LAT_S + 5) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("b2b_drain", 96'(vld(1'b1)), 96'(1));

        // one valid alone never gets accepted
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'd50, 32'd5);
        drive(1'b0, 1'b0, 1'b1, 32'd50, 32'd5);
        ok = 1'b1;
        repeat (LAT_S + 4) begin
            @(posedge clk);
            #1;
            if (!rdy(1'b1) || !rdy(1'b0) || vld(1'b1) || vld(1'b0)) ok = 1'b0;
        end
        chk("single_valid_no_accept", 96'(ok), 96'(1));
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // reset in the middle of an operation
        do_op(1'b0, 32'hDEAD_BEEF, 32'd3);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 32'd1000, 32'd7);
        drive(1'b0, 1'b1, 1'b1, 32'd1000, 32'd7);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midop_reset_s", 96'({rdy(1'b1), vld(1'b1), res(1'b1)}), 96'({1'b1, 1'b0, 65'h0}));
        chk("midop_reset_u", 96'({rdy(1'b0), vld(1'b0), res(1'b0)}), 96'({1'b1, 1'b0, 65'h0}));
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (LAT_S + 4) begin
            @(posedge clk);
            #1;
            if (vld(1'b1) || vld(1'b0)) ok = 1'b0;
        end
        chk("discarded_no_strobe", 96'(ok), 96'(1));
        do_op(1'b1, 32'd9, 32'd3);
        chk("lit_9_3_s", 96'(res(1'b1)), 96'({1'b0, 32'd3, 32'd0}));
        do_op(1'b0, 32'd9, 32'd3);
        chk("lit_9_3_u", 96'(res(1'b0)), 96'({1'b0, 32'd3, 32'd0}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
